// File: rtl/regfile_read_port.sv
// Register file with two registered operand reads, same-edge write bypass and a
// pending-load scoreboard. Define REGFILE_RESET_EN to clear the array on reset.
module regfile_read_port #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_req,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rd_valid,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ld_issue,
    input  logic [AW-1:0]   ld_rd,
    output logic            stall
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] pending_q, pending_d;
    logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             wr_en, hit1, hit2, accept;

    assign wr_en  = wb_en && (wb_addr != '0);
    assign hit1   = wb_en && (wb_addr == rs1_addr);
    assign hit2   = wb_en && (wb_addr == rs2_addr);
    // A register retiring on this edge never stalls: the bypass supplies it.
    assign stall  = rd_req && ((pending_q[rs1_addr] && !hit1) ||
                               (pending_q[rs2_addr] && !hit2));
    assign accept = rd_req && !stall;

    always_comb begin
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rd_valid_d = accept;
        if (accept) begin
            if (rs1_addr == '0)
                rs1_data_d = '0;
            else if (hit1)
                rs1_data_d = wb_data;
            else
                rs1_data_d = regs_q[rs1_addr];

            if (rs2_addr == '0)
                rs2_data_d = '0;
            else if (hit2)
                rs2_data_d = wb_data;
            else
                rs2_data_d = regs_q[rs2_addr];
        end
    end

    // Clear before set so a newly issued load supersedes one retiring to the same register.
    always_comb begin
        pending_d = pending_q;
        if (wb_en)
            pending_d[wb_addr] = 1'b0;
        if (ld_issue && (ld_rd != '0))
            pending_d[ld_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_valid_q <= 1'b0;
            pending_q  <= '0;
        end else begin
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rd_valid_q <= rd_valid_d;
            pending_q  <= pending_d;
        end
    end

`ifdef REGFILE_RESET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[wb_addr] <= wb_data;
        end
    end
`else
    // No reset so the array can map onto RAM-style storage; x0 is masked on read.
    always_ff @(posedge clk) begin
        if (wr_en)
            regs_q[wb_addr] <= wb_data;
    end
`endif

    assign rs1_data = rs1_data_q;
    assign rs2_data = rs2_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: directed scenarios followed by random traffic,
// all checked against an array-based reference model of the register file.
module tb_regfile_read_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_req = 1'b0;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0;
    logic [31:0] rs1_data, rs2_data;
    logic        rd_valid;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        ld_issue = 1'b0;
    logic [4:0]  ld_rd = '0;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_mem  [32];
    bit          m_wr   [32];
    bit          m_pend [32];
    logic [31:0] m_d1, m_d2;
    bit          m_k1, m_k2, m_v;

    regfile_read_port #(.XLEN(32), .NREGS(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .rd_req(rd_req),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_valid(rd_valid),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ld_issue(ld_issue), .ld_rd(ld_rd), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_stall();
        bit s1, s2;
        s1 = m_pend[rs1_addr] && !(wb_en && wb_addr == rs1_addr);
        s2 = m_pend[rs2_addr] && !(wb_en && wb_addr == rs2_addr);
        return rd_req && (s1 || s2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_pend[i] = 1'b0;
`ifdef REGFILE_RESET_EN
            m_mem[i] = '0;
            m_wr[i]  = 1'b1;
`else
            m_wr[i]  = (i == 0);
            m_mem[i] = '0;
`endif
        end
        m_d1 = '0; m_d2 = '0; m_k1 = 1'b1; m_k2 = 1'b1; m_v = 1'b0;
    endtask

    task automatic model_edge();
        bit acc;
        acc = rd_req && !model_stall();
        m_v = acc;
        if (acc) begin
            if (rs1_addr == 0) begin m_d1 = '0; m_k1 = 1'b1; end
            else if (wb_en && wb_addr == rs1_addr) begin m_d1 = wb_data; m_k1 = 1'b1; end
            else begin m_d1 = m_mem[rs1_addr]; m_k1 = m_wr[rs1_addr]; end
            if (rs2_addr == 0) begin m_d2 = '0; m_k2 = 1'b1; end
            else if (wb_en && wb_addr == rs2_addr) begin m_d2 = wb_data; m_k2 = 1'b1; end
            else begin m_d2 = m_mem[rs2_addr]; m_k2 = m_wr[rs2_addr]; end
        end
        if (wb_en && wb_addr != 0) begin
            m_mem[wb_addr] = wb_data;
            m_wr[wb_addr]  = 1'b1;
        end
        if (wb_en) m_pend[wb_addr] = 1'b0;
        if (ld_issue && ld_rd != 0) m_pend[ld_rd] = 1'b1;
    endtask

    task automatic step(input bit rq, input logic [4:0] a1, input logic [4:0] a2,
                        input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input bit li, input logic [4:0] lr);
        @(negedge clk);
        rd_req = rq; rs1_addr = a1; rs2_addr = a2;
        wb_en = we; wb_addr = wa; wb_data = wd;
        ld_issue = li; ld_rd = lr;
        #1;
        check("stall", {31'b0, stall}, {31'b0, model_stall()});
        @(posedge clk);
        model_edge();
        #1;
        check("rd_valid", {31'b0, rd_valid}, {31'b0, m_v});
        if (m_k1) check("rs1_data", rs1_data, m_d1);
        if (m_k2) check("rs2_data", rs2_data, m_d2);
    endtask

    initial begin
        model_reset();
        #2;
        check("reset rd_valid", {31'b0, rd_valid}, 32'd0);
        check("reset rs1_data", rs1_data, 32'd0);
        check("reset rs2_data", rs2_data, 32'd0);
        check("reset stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic write then read
        step(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        step(1, 5, 0, 0, 0, 32'h0, 0, 0);
        check("basic rs1", rs1_data, 32'hDEADBEEF);
        check("basic rs2", rs2_data, 32'h0);
        check("basic valid", {31'b0, rd_valid}, 32'd1);

        // x0 protection, including write to x0 bypass attempt
        step(0, 0, 0, 1, 0, 32'h12345678, 0, 0);
        step(1, 0, 0, 1, 0, 32'h12345678, 0, 0);
        check("x0 rs1", rs1_data, 32'h0);

        // same-edge bypass on both ports
        step(0, 0, 0, 1, 7, 32'h11, 0, 0);
        step(1, 7, 7, 1, 7, 32'h22, 0, 0);
        check("bypass rs1", rs1_data, 32'h22);
        check("bypass rs2", rs2_data, 32'h22);

        // load-use stall and release by write-back
        step(0, 0, 0, 0, 0, 32'h0, 1, 9);
        step(1, 0, 9, 0, 0, 32'h0, 0, 0);
        check("loaduse valid stalled", {31'b0, rd_valid}, 32'd0);
        step(1, 0, 9, 1, 9, 32'hA5, 0, 0);
        check("loaduse rs2", rs2_data, 32'hA5);
        check("loaduse valid", {31'b0, rd_valid}, 32'd1);

        // set/clear collision: set wins
        step(0, 0, 0, 1, 3, 32'h33, 1, 3);
        @(negedge clk);
        rd_req = 1; rs1_addr = 3; rs2_addr = 0; wb_en = 0; ld_issue = 0;
        #1;
        check("collision stall", {31'b0, stall}, 32'd1);
        @(posedge clk);
        model_edge();
        #1;
        check("collision valid", {31'b0, rd_valid}, 32'd0);

        // async reset while stalled with a read just delivered
        step(1, 5, 0, 1, 3, 32'h44, 1, 4);
        check("pre-reset valid", {31'b0, rd_valid}, 32'd1);
        rd_req = 1; rs1_addr = 4; rs2_addr = 0; wb_en = 0; ld_issue = 0;
        #1;
        check("pre-reset stall", {31'b0, stall}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async stall", {31'b0, stall}, 32'd0);
        check("async valid", {31'b0, rd_valid}, 32'd0);
        check("async rs1", rs1_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 5, 4, 0, 0, 32'h0, 0, 0);
        check("post-reset valid", {31'b0, rd_valid}, 32'd1);
`ifdef REGFILE_RESET_EN
        check("post-reset x5", rs1_data, 32'h0);
`endif

        // random traffic over a narrow address window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            logic [4:0] a1, a2, wa, lr;
            bit wide;
            wide = ($urandom_range(0, 9) == 0);
            a1 = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            a2 = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wa = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            lr = 5'($urandom_range(0, 7));
            step($urandom_range(0, 9) < 7, a1, a2, $urandom_range(0, 1) == 1, wa,
                 $urandom, $urandom_range(0, 3) == 0, lr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
